// File: rtl/serial_pattern_gen.sv
// Serial bit-stream transmitter: sends a captured 1..WIDTH-bit pattern LSB first,
// with optional repetitions separated by GAP idle cycles. All outputs are registered.
module serial_pattern_gen #(
    parameter int WIDTH = 16,
    parameter int LENW  = 5,
    parameter int RPTW  = 4,
    parameter int GAP   = 0
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Start,
    input  logic [WIDTH-1:0] Data,
    input  logic [LENW-1:0]  Len,
    input  logic [RPTW-1:0]  Repeat,
    output logic             w,
    output logic             Valid,
    output logic             Busy,
    output logic             Done
);

    localparam int GAPW = (GAP < 2) ? 1 : $clog2(GAP + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_GAP,
        S_DONE
    } state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] dat_q, dat_n;
    logic [WIDTH-1:0] shreg, shreg_n;
    logic [LENW-1:0]  len_q, len_n;
    logic [LENW-1:0]  bit_cnt, bit_cnt_n;
    logic [RPTW-1:0]  rpt_q, rpt_n;
    logic [RPTW-1:0]  rpt_cnt, rpt_cnt_n;
    logic [GAPW-1:0]  gap_cnt, gap_cnt_n;
    logic             w_n, valid_n, busy_n, done_n;
    logic [LENW-1:0]  len_clamped;

    always_comb begin
        len_clamped = Len;
        if (Len == '0 || Len > LENW'(WIDTH))
            len_clamped = LENW'(WIDTH);
    end

    // Outputs are computed one cycle ahead so they leave the module straight from flops;
    // bit_cnt counts bits already placed on w, so bit_cnt==len_q marks the last bit.
    always_comb begin
        state_n   = state;
        dat_n     = dat_q;
        shreg_n   = shreg;
        len_n     = len_q;
        bit_cnt_n = bit_cnt;
        rpt_n     = rpt_q;
        rpt_cnt_n = rpt_cnt;
        gap_cnt_n = gap_cnt;
        w_n       = 1'b0;
        valid_n   = 1'b0;
        busy_n    = 1'b1;
        done_n    = 1'b0;
        case (state)
            S_IDLE: begin
                busy_n = 1'b0;
                if (Start) begin
                    dat_n     = Data;
                    len_n     = len_clamped;
                    rpt_n     = Repeat;
                    rpt_cnt_n = '0;
                    shreg_n   = Data >> 1;
                    w_n       = Data[0];
                    valid_n   = 1'b1;
                    busy_n    = 1'b1;
                    bit_cnt_n = LENW'(1);
                    state_n   = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (bit_cnt == len_q) begin
                    if (rpt_cnt < rpt_q) begin
                        rpt_cnt_n = rpt_cnt + RPTW'(1);
                        if (GAP > 0) begin
                            gap_cnt_n = GAPW'(1);
                            state_n   = S_GAP;
                        end else begin
                            shreg_n   = dat_q >> 1;
                            w_n       = dat_q[0];
                            valid_n   = 1'b1;
                            bit_cnt_n = LENW'(1);
                        end
                    end else begin
                        done_n  = 1'b1;
                        state_n = S_DONE;
                    end
                end else begin
                    shreg_n   = shreg >> 1;
                    w_n       = shreg[0];
                    valid_n   = 1'b1;
                    bit_cnt_n = bit_cnt + LENW'(1);
                end
            end
            S_GAP: begin
                if (gap_cnt == GAPW'(GAP)) begin
                    shreg_n   = dat_q >> 1;
                    w_n       = dat_q[0];
                    valid_n   = 1'b1;
                    bit_cnt_n = LENW'(1);
                    state_n   = S_SHIFT;
                end else begin
                    gap_cnt_n = gap_cnt + GAPW'(1);
                end
            end
            S_DONE: begin
                busy_n    = 1'b0;
                bit_cnt_n = '0;
                rpt_cnt_n = '0;
                gap_cnt_n = '0;
                state_n   = S_IDLE;
            end
            default: begin
                busy_n  = 1'b0;
                state_n = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state   <= S_IDLE;
            dat_q   <= '0;
            shreg   <= '0;
            len_q   <= '0;
            bit_cnt <= '0;
            rpt_q   <= '0;
            rpt_cnt <= '0;
            gap_cnt <= '0;
            w       <= 1'b0;
            Valid   <= 1'b0;
            Busy    <= 1'b0;
            Done    <= 1'b0;
        end else begin
            state   <= state_n;
            dat_q   <= dat_n;
            shreg   <= shreg_n;
            len_q   <= len_n;
            bit_cnt <= bit_cnt_n;
            rpt_q   <= rpt_n;
            rpt_cnt <= rpt_cnt_n;
            gap_cnt <= gap_cnt_n;
            w       <= w_n;
            Valid   <= valid_n;
            Busy    <= busy_n;
            Done    <= done_n;
        end
    end

endmodule
